// File: rtl/tx_defs.sv
// Shared Tx-path definitions: arbiter state encoding, default AXI-Stream widths
// (also used by the rx engine) and the round-robin pointer helper.
package tx_defs;

  localparam int DEFAULT_DATA_WIDTH = 64;
  localparam int DEFAULT_KEEP_WIDTH = DEFAULT_DATA_WIDTH / 8;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  // Next round-robin start point after requester cur finishes, wrapping at num.
  function automatic int rr_next(input int cur, input int num);
    return (cur + 1 >= num) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/tx_tlp_arbiter_if.sv
// AXI-Stream bundle around the Tx arbiter: NUM_REQ requester lanes in, one lane out
// to the core. The slave modport is the arbiter's view; master is the surrounding logic.
interface tx_tlp_arbiter_if #(
  parameter int DATA_WIDTH = tx_defs::DEFAULT_DATA_WIDTH,
  parameter int KEEP_WIDTH = tx_defs::DEFAULT_KEEP_WIDTH,
  parameter int NUM_REQ    = 2
);

  logic [NUM_REQ*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_REQ*KEEP_WIDTH-1:0] s_axis_tkeep;
  logic [NUM_REQ-1:0]            s_axis_tvalid;
  logic [NUM_REQ-1:0]            s_axis_tlast;
  logic [NUM_REQ-1:0]            s_axis_tready;

  logic [DATA_WIDTH-1:0]         m_axis_tdata;
  logic [KEEP_WIDTH-1:0]         m_axis_tkeep;
  logic                          m_axis_tvalid;
  logic                          m_axis_tlast;
  logic                          m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );

endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer: full throughput, outputs taken straight from the
// head register, and s_tready derived only from the fill count.
module axis_skid_buffer
  import tx_defs::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int KEEP_WIDTH = DEFAULT_KEEP_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [KEEP_WIDTH-1:0] s_tkeep,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [KEEP_WIDTH-1:0] m_tkeep,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready
);

  localparam int W = DATA_WIDTH + KEEP_WIDTH + 1;

  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign s_tready = (count != 2'd2);
  assign m_tvalid = (count != 2'd0);
  assign {m_tlast, m_tkeep, m_tdata} = head;

  assign push = s_tvalid && s_tready;
  assign pop  = m_tvalid && m_tready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 2'd0;
      // NOTE: the data registers are reset as well because the head drives m_axis
      // directly and must read as zero out of reset.
      head  <= '0;
      tail  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (count)
        2'd0: begin
          if (push) begin
            head  <= {s_tlast, s_tkeep, s_tdata};
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head <= {s_tlast, s_tkeep, s_tdata};
          end else if (push) begin
            tail  <= {s_tlast, s_tkeep, s_tdata};
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        2'd2: begin
          // Full: no push is possible, the tail moves up when the head leaves.
          if (pop) begin
            head  <= tail;
            count <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/tx_tlp_arbiter.sv
// Packet-granular round-robin arbiter sharing the core's Tx AXI-Stream port between
// NUM_REQ TLP sources; a grant is held from first beat to accepted tlast.
module tx_tlp_arbiter
  import tx_defs::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int KEEP_WIDTH = DEFAULT_KEEP_WIDTH,
  parameter int NUM_REQ    = 2,
  parameter int ID_WIDTH   = 1
) (
  input  logic                clk,
  input  logic                reset,
  tx_tlp_arbiter_if.slave     bus,
  output logic [ID_WIDTH-1:0] grant_id,
  output logic                busy
);

  arb_state_e            state;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   winner;
  logic                  any_valid;

  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  skid_ready;
  logic                  accept_last;

  // Round-robin search: the smallest offset from rr_ptr with tvalid set wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    winner    = rr_ptr;
    any_valid = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (bus.s_axis_tvalid[j] && ((int'(rr_ptr) + i) % NUM_REQ == j)) begin
          winner    = ID_WIDTH'(j);
          any_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_data          = '0;
    sel_keep          = '0;
    sel_valid         = 1'b0;
    sel_last          = 1'b0;
    bus.s_axis_tready = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (ID_WIDTH'(j) == grant_id) begin
        sel_data  = bus.s_axis_tdata[j*DATA_WIDTH +: DATA_WIDTH];
        sel_keep  = bus.s_axis_tkeep[j*KEEP_WIDTH +: KEEP_WIDTH];
        sel_valid = bus.s_axis_tvalid[j];
        sel_last  = bus.s_axis_tlast[j];
        bus.s_axis_tready[j] = (state == ARB_LOCK) && skid_ready;
      end
    end
  end

  assign accept_last = (state == ARB_LOCK) && sel_valid && skid_ready && sel_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ARB_IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_valid) begin
            grant_id <= winner;
            busy     <= 1'b1;
            state    <= ARB_LOCK;
          end
        end
        ARB_LOCK: begin
          if (accept_last) begin
            rr_ptr <= ID_WIDTH'(rr_next(int'(grant_id), NUM_REQ));
            busy   <= 1'b0;
            state  <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Beats still in the skid buffer drain independently of the next arbitration.
  axis_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .KEEP_WIDTH(KEEP_WIDTH)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .s_tdata  (sel_data),
    .s_tkeep  (sel_keep),
    .s_tvalid ((state == ARB_LOCK) && sel_valid),
    .s_tlast  (sel_last),
    .s_tready (skid_ready),
    .m_tdata  (bus.m_axis_tdata),
    .m_tkeep  (bus.m_axis_tkeep),
    .m_tvalid (bus.m_axis_tvalid),
    .m_tlast  (bus.m_axis_tlast),
    .m_tready (bus.m_axis_tready)
  );

endmodule

// File: tb/tb_tx_tlp_arbiter.sv
// Directed bench for tx_tlp_arbiter: queued per-requester sources, an output log,
// and hand-computed expectations for ordering, latency, backpressure and reset.
module tb_tx_tlp_arbiter;
  import tx_defs::*;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int NR = 2;
  localparam int IW = 1;

  typedef struct { logic [DW-1:0] data; logic [KW-1:0] keep; logic last; } beat_t;
  typedef struct { logic [DW-1:0] data; logic [KW-1:0] keep; logic last; int cyc; } obeat_t;
  typedef struct { int cyc; int req; } acc_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [IW-1:0] grant_id;
  logic          busy;

  tx_tlp_arbiter_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .NUM_REQ(NR)) bus ();

  tx_tlp_arbiter #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .NUM_REQ(NR), .ID_WIDTH(IW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  beat_t   src_q[NR][$];
  obeat_t  out_q[$];
  acc_t    acc_q[$];
  logic [NR-1:0] pause;
  int      cyc = 0;
  int      total = 0;
  int      bad = 0;
  int      multi_rdy = 0;
  int      t0;

  logic          busy_log [0:1023];
  logic [IW-1:0] gid_log  [0:1023];
  logic [NR-1:0] trdy_log [0:1023];
  logic          mval_log [0:1023];
  logic [DW-1:0] mdat_log [0:1023];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int r = 0; r < NR; r++) begin
      if (src_q[r].size() > 0 && !pause[r]) begin
        bus.s_axis_tvalid[r]             = 1'b1;
        bus.s_axis_tdata[r*DW +: DW]     = src_q[r][0].data;
        bus.s_axis_tkeep[r*KW +: KW]     = src_q[r][0].keep;
        bus.s_axis_tlast[r]              = src_q[r][0].last;
      end else begin
        bus.s_axis_tvalid[r]             = 1'b0;
        bus.s_axis_tdata[r*DW +: DW]     = '0;
        bus.s_axis_tkeep[r*KW +: KW]     = '0;
        bus.s_axis_tlast[r]              = 1'b0;
      end
    end
  endtask

  // Observe at the falling edge, then advance to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    busy_log[cyc] = busy;
    gid_log[cyc]  = grant_id;
    trdy_log[cyc] = bus.s_axis_tready;
    mval_log[cyc] = bus.m_axis_tvalid;
    mdat_log[cyc] = bus.m_axis_tdata;
    if ($countones(bus.s_axis_tready) > 1) multi_rdy++;
    for (int r = 0; r < NR; r++) begin
      if (bus.s_axis_tvalid[r] && bus.s_axis_tready[r]) begin
        acc_q.push_back('{cyc, r});
        if (src_q[r].size() > 0) src_q[r].delete(0);
      end
    end
    if (bus.m_axis_tvalid && bus.m_axis_tready)
      out_q.push_back('{bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast, cyc});
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  function automatic obeat_t out_at(input int i);
    obeat_t dflt;
    dflt = '{'0, '0, 1'b0, -1};
    if (i < out_q.size()) return out_q[i];
    return dflt;
  endfunction

  function automatic acc_t acc_at(input int i);
    acc_t dflt;
    dflt = '{-1, -1};
    if (i < acc_q.size()) return acc_q[i];
    return dflt;
  endfunction

  task automatic add_tlp(input int r, input logic [DW-1:0] base, input int n,
                         input logic [KW-1:0] keep);
    for (int b = 0; b < n; b++)
      src_q[r].push_back('{base + DW'(b), keep, (b == n - 1)});
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    for (int r = 0; r < NR; r++) src_q[r].delete();
    pause = '0;
    drive();
    tick();
    tick();
    reset = 1'b0;
    out_q.delete();
    acc_q.delete();
  endtask

  // Bounded wait for n output beats, then a short drain to catch duplicates.
  task automatic run_until(input int n, input int budget, input string tag);
    int k = 0;
    while (out_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    repeat (4) tick();
    check({tag, "_count"}, 64'(out_q.size()), 64'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pause = '0;
    bus.m_axis_tready = 1'b1;
    drive();
    repeat (3) @(posedge clk);
    #1;
    check("rst_mvalid", 64'(bus.m_axis_tvalid), 64'd0);
    check("rst_mdata",  64'(bus.m_axis_tdata), 64'd0);
    check("rst_tready", 64'(bus.s_axis_tready), 64'd0);
    check("rst_busy",   64'(busy), 64'd0);
    check("rst_gid",    64'(grant_id), 64'd0);
    reset = 1'b0;

    // 3-beat TLP from req0, output sink always ready.
    t0 = cyc;
    add_tlp(0, 64'hA0, 3, 8'hFF);
    drive();
    run_until(3, 20, "t1");
    for (int b = 0; b < 3; b++) begin
      check("t1_data", out_at(b).data, 64'hA0 + 64'(b));
      check("t1_last", 64'(out_at(b).last), 64'(b == 2));
      check("t1_lat",  64'(out_at(b).cyc - t0), 64'(2 + b));
    end
    check("t1_gid",      64'(gid_log[t0+1]), 64'd0);
    check("t1_busy_on",  64'(busy_log[t0+3]), 64'd1);
    check("t1_busy_off", 64'(busy_log[t0+4]), 64'd0);
    check("t1_rr_ptr",   64'(dut.rr_ptr), 64'd1);

    // Both requesters continuously valid with 2-beat TLPs.
    apply_reset();
    t0 = cyc;
    add_tlp(0, 64'h100, 2, 8'hFF);
    add_tlp(1, 64'h200, 2, 8'hFF);
    add_tlp(0, 64'h110, 2, 8'hFF);
    add_tlp(1, 64'h210, 2, 8'hFF);
    drive();
    run_until(8, 60, "t2");
    begin
      logic [DW-1:0] exp2 [8];
      exp2 = '{64'h100, 64'h101, 64'h200, 64'h201, 64'h110, 64'h111, 64'h210, 64'h211};
      for (int i = 0; i < 8; i++) check("t2_order", out_at(i).data, exp2[i]);
    end
    check("t2_first_acc", 64'(acc_at(0).cyc - t0), 64'd1);
    for (int g = 1; g < 4; g++)
      check("t2_gap", 64'(acc_at(2*g).cyc - acc_at(2*g-1).cyc), 64'd2);

    // req1 pauses mid-TLP for 5 cycles while req0 waits.
    apply_reset();
    t0 = cyc;
    add_tlp(1, 64'h300, 3, 8'hFF);
    drive();
    tick();
    add_tlp(0, 64'h400, 2, 8'hFF);
    drive();
    pause[1] = 1'b1;
    repeat (5) tick();
    pause[1] = 1'b0;
    run_until(5, 40, "t3");
    for (int k = 2; k <= 6; k++) check("t3_ready_pause", 64'(trdy_log[t0+k]), 64'b10);
    check("t3_gid_hold", 64'(gid_log[t0+4]), 64'd1);
    begin
      logic [DW-1:0] exp3 [5];
      exp3 = '{64'h300, 64'h301, 64'h302, 64'h400, 64'h401};
      for (int i = 0; i < 5; i++) check("t3_order", out_at(i).data, exp3[i]);
    end

    // Sink stalls for 10 cycles during a 6-beat TLP.
    apply_reset();
    bus.m_axis_tready = 1'b0;
    t0 = cyc;
    add_tlp(0, 64'h500, 6, 8'hFF);
    drive();
    repeat (10) tick();
    check("t4_rdy_c1",   64'(trdy_log[t0+1][0]), 64'd1);
    check("t4_rdy_c2",   64'(trdy_log[t0+2][0]), 64'd1);
    check("t4_rdy_full", 64'(trdy_log[t0+3][0]), 64'd0);
    check("t4_rdy_c9",   64'(trdy_log[t0+9][0]), 64'd0);
    check("t4_held",     64'(acc_q.size()), 64'd2);
    check("t4_mval_c2",  64'(mval_log[t0+2]), 64'd1);
    check("t4_mdat_c2",  mdat_log[t0+2], 64'h500);
    check("t4_mval_c9",  64'(mval_log[t0+9]), 64'd1);
    check("t4_mdat_c9",  mdat_log[t0+9], 64'h500);
    bus.m_axis_tready = 1'b1;
    run_until(6, 40, "t4");
    for (int b = 0; b < 6; b++) begin
      check("t4_data", out_at(b).data, 64'h500 + 64'(b));
      check("t4_last", 64'(out_at(b).last), 64'(b == 5));
    end

    // Alternating single-beat TLPs with partial byte enables.
    apply_reset();
    add_tlp(0, 64'h600, 1, 8'h0F);
    add_tlp(1, 64'h601, 1, 8'h0F);
    add_tlp(0, 64'h602, 1, 8'h0F);
    add_tlp(1, 64'h603, 1, 8'h0F);
    drive();
    run_until(4, 40, "t5");
    for (int i = 0; i < 4; i++) begin
      check("t5_data", out_at(i).data, 64'h600 + 64'(i));
      check("t5_keep", 64'(out_at(i).keep), 64'h0F);
      check("t5_last", 64'(out_at(i).last), 64'd1);
      check("t5_req",  64'(acc_at(i).req), 64'(i % 2));
    end

    // Reset asserted while the 2nd beat of a 4-beat TLP is presented.
    apply_reset();
    add_tlp(0, 64'h700, 4, 8'hFF);
    drive();
    tick();
    tick();
    check("t6_pre_mval", 64'(bus.m_axis_tvalid), 64'd1);
    reset = 1'b1;
    #1;
    check("t6_mval",   64'(bus.m_axis_tvalid), 64'd0);
    check("t6_mdata",  bus.m_axis_tdata, 64'd0);
    check("t6_tready", 64'(bus.s_axis_tready), 64'd0);
    check("t6_busy",   64'(busy), 64'd0);
    apply_reset();
    add_tlp(1, 64'h800, 2, 8'hFF);
    drive();
    run_until(2, 20, "t6");
    check("t6_data0", out_at(0).data, 64'h800);
    check("t6_data1", out_at(1).data, 64'h801);
    check("t6_req",   64'(acc_at(0).req), 64'd1);

    check("one_hot_ready", 64'(multi_rdy), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
